atpg_response_checker: RTL

- Tester-side counterpart to the fault-inserted circuit-under-test (CUT) netlists: applies test patterns to the CUT primary inputs and reads back its primary outputs.
- Per vector: accepts {pattern, expected response, mask}, drives the pattern, waits a settle window, then samples, compares and compacts the response.
- Reports pass/fail, mismatch count, first failing vector and a MISR signature to the ATPG flow.

---
 rtl/atpg_pkg.sv | 28 ++
 rtl/atpg_misr.sv | 39 +++
 rtl/atpg_response_checker.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/atpg_pkg.sv
// Shared types and helpers for the ATPG tester-side blocks: FSM encoding,
// default MISR constants and the MISR step function.
package atpg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_VEC = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_CAPTURE  = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam logic [15:0] DEF_POLY = 16'h8005;
  localparam logic [15:0] DEF_SEED = 16'h0000;

  // One MISR step on a w-bit register held in the low bits of a 64-bit container.
  function automatic logic [63:0] misr_next(input logic [63:0] sig,
                                            input logic [63:0] poly,
                                            input logic [63:0] din,
                                            input int          w);
    logic [63:0] keep;
    logic [63:0] fb;
    keep = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    fb   = (((sig >> (w - 1)) & 64'd1) != 64'd0) ? poly : 64'd0;
    return ((sig << 1) ^ fb ^ din) & keep;
  endfunction

endpackage

// File: rtl/atpg_misr.sv
// Multiple-input signature register compacting the masked CUT response.
module atpg_misr
  import atpg_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter int               PO_W  = 4,
  parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED  = DEF_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [PO_W-1:0]  din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_sig_next;

  // Next signature value for the current input word.
  always_comb begin
    w_sig_next = SIG_W'(misr_next(64'(r_sig), 64'(POLY), 64'(din), SIG_W));
  end

  // Signature register; clear takes priority over a capture step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig <= SEED;
    end else if (clear) begin
      r_sig <= SEED;
    end else if (en) begin
      r_sig <= w_sig_next;
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/atpg_response_checker.sv
// Applies ATPG vectors to a CUT, waits a settle window, then compares and
// compacts the masked response, reporting pass/fail and first-failure data.
module atpg_response_checker
  import atpg_pkg::*;
#(
  parameter int               PI_W   = 7,
  parameter int               PO_W   = 4,
  parameter int               SETTLE = 2,
  parameter int               IDX_W  = 16,
  parameter int               SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED   = DEF_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [PI_W-1:0]  vec_pattern,
  input  logic [PO_W-1:0]  vec_expect,
  input  logic [PO_W-1:0]  vec_mask,
  input  logic             vec_last,
  output logic [PI_W-1:0]  cut_pi,
  input  logic [PO_W-1:0]  cut_po,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IDX_W-1:0] vec_count,
  output logic [IDX_W-1:0] fail_count,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic [PO_W-1:0]  first_fail_diff,
  output logic [SIG_W-1:0] signature
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [PI_W-1:0]  r_cut_pi;
  logic [PO_W-1:0]  r_expect;
  logic [PO_W-1:0]  r_mask;
  logic             r_last;
  logic [IDX_W-1:0] r_vec_count;
  logic [IDX_W-1:0] r_fail_count;
  logic [IDX_W-1:0] r_ff_idx;
  logic [PO_W-1:0]  r_ff_diff;

  logic             w_session_start;
  logic             w_handshake;
  logic             w_capture;
  logic [PO_W-1:0]  w_masked_po;
  logic [PO_W-1:0]  w_diff;

  assign w_session_start = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_handshake     = vec_valid && (r_state == ST_WAIT_VEC);
  assign w_capture       = (r_state == ST_CAPTURE);
  // Masking after the XOR keeps unknowns on don't-care outputs out of diff and MISR.
  assign w_masked_po     = cut_po & r_mask;
  assign w_diff          = (cut_po ^ r_expect) & r_mask;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) w_next_state = ST_WAIT_VEC;
        else       w_next_state = r_state;
      end
      ST_WAIT_VEC: begin
        if (vec_valid) w_next_state = ST_SETTLE;
        else           w_next_state = ST_WAIT_VEC;
      end
      ST_SETTLE: begin
        if (r_cnt == {CNT_W{1'b0}}) w_next_state = ST_CAPTURE;
        else                        w_next_state = ST_SETTLE;
      end
      ST_CAPTURE: begin
        if (r_last) w_next_state = ST_DONE;
        else        w_next_state = ST_WAIT_VEC;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM status outputs decoded from the state register.
  always_comb begin
    vec_ready = (r_state == ST_WAIT_VEC);
    busy      = (r_state == ST_WAIT_VEC) || (r_state == ST_SETTLE) || (r_state == ST_CAPTURE);
    done      = (r_state == ST_DONE);
    pass      = (r_state == ST_DONE) && (r_fail_count == {IDX_W{1'b0}});
  end

  // Vector latch, settle counter and result bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= {CNT_W{1'b0}};
      r_cut_pi     <= {PI_W{1'b0}};
      r_expect     <= {PO_W{1'b0}};
      r_mask       <= {PO_W{1'b0}};
      r_last       <= 1'b0;
      r_vec_count  <= {IDX_W{1'b0}};
      r_fail_count <= {IDX_W{1'b0}};
      r_ff_idx     <= {IDX_W{1'b0}};
      r_ff_diff    <= {PO_W{1'b0}};
    end else if (w_session_start) begin
      r_vec_count  <= {IDX_W{1'b0}};
      r_fail_count <= {IDX_W{1'b0}};
      r_ff_idx     <= {IDX_W{1'b0}};
      r_ff_diff    <= {PO_W{1'b0}};
    end else if (w_handshake) begin
      r_cut_pi <= vec_pattern;
      r_expect <= vec_expect;
      r_mask   <= vec_mask;
      r_last   <= vec_last;
      r_cnt    <= CNT_W'(SETTLE - 1);
    end else if (r_state == ST_SETTLE) begin
      if (r_cnt != {CNT_W{1'b0}}) r_cnt <= r_cnt - CNT_W'(1);
    end else if (w_capture) begin
      if (w_diff != {PO_W{1'b0}}) begin
        if (r_fail_count != {IDX_W{1'b1}}) r_fail_count <= r_fail_count + IDX_W'(1);
        if (r_fail_count == {IDX_W{1'b0}}) begin
          r_ff_idx  <= r_vec_count;
          r_ff_diff <= w_diff;
        end
      end
      r_vec_count <= r_vec_count + IDX_W'(1);
    end
  end

  atpg_misr #(
    .SIG_W (SIG_W),
    .PO_W  (PO_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk   (clk),
    .rst   (rst),
    .clear (w_session_start),
    .en    (w_capture),
    .din   (w_masked_po),
    .sig   (signature)
  );

  assign cut_pi          = r_cut_pi;
  assign vec_count       = r_vec_count;
  assign fail_count      = r_fail_count;
  assign first_fail_idx  = r_ff_idx;
  assign first_fail_diff = r_ff_diff;

endmodule
